// File: rtl/spi_pkg.sv
// Shared constants, register map and state type for the SPI register-access initiator.
package spi_pkg;

    localparam int unsigned SPI_FRAME_W = 16;
    localparam int unsigned SPI_RW_BIT  = 15;
    localparam int unsigned SPI_ADDR_W  = 7;
    localparam int unsigned SPI_DATA_W  = 8;

    localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_7_0   = 7'h00;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_15_8  = 7'h01;
    localparam logic [SPI_ADDR_W-1:0] REG_PWM_EN_7_0   = 7'h02;
    localparam logic [SPI_ADDR_W-1:0] REG_PWM_EN_15_8  = 7'h03;
    localparam logic [SPI_ADDR_W-1:0] REG_PWM_DUTY     = 7'h04;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} spi_ctrl_state_t;

    function automatic logic [SPI_FRAME_W-1:0] spi_frame(input logic rw,
                                                         input logic [SPI_ADDR_W-1:0] addr,
                                                         input logic [SPI_DATA_W-1:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Loadable down-counter marking the last system clock of each SCLK half-period.
module spi_half_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLK_DIV);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CntW'(CLK_DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI initiator: one 16-bit register-access frame per start handshake, CIPO captured
// into rdata. All outputs are registered.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rw,
    input  logic [SPI_ADDR_W-1:0] addr,
    input  logic [SPI_DATA_W-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic [SPI_DATA_W-1:0] rdata,
    input  logic                  cipo,
    output logic                  sclk,
    output logic                  copi,
    output logic                  ncs
);

    // The peripheral double-synchronises its inputs, so a half-period must span 2+ clocks.
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_controller: CLK_DIV must be at least 2");
    end

    spi_ctrl_state_t        state_q;
    logic [SPI_FRAME_W-1:0] tx_q;
    logic [SPI_DATA_W-1:0]  rx_q;
    logic [3:0]             bit_cnt_q;
    logic                   last_q;
    logic                   tick;
    logic                   load;

    // Every non-idle state lasts exactly one half-period, so each tick is a state change.
    always_comb begin
        load = 1'b0;
        if (state_q == IDLE) begin
            load = start;
        end else begin
            load = tick;
        end
    end

    spi_half_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_half_tick (
        .clk (clk),
        .rst (rst),
        .load(load),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            rdata     <= '0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        tx_q      <= spi_frame(rw, addr, wdata);
                        bit_cnt_q <= '0;
                        last_q    <= 1'b0;
                        ready     <= 1'b0;
                        ncs       <= 1'b0;
                        copi      <= rw;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sclk    <= 1'b1;
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        rx_q      <= {rx_q[SPI_DATA_W-2:0], cipo};
                        tx_q      <= {tx_q[SPI_FRAME_W-2:0], 1'b0};
                        copi      <= tx_q[SPI_RW_BIT-1];
                        sclk      <= 1'b0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        last_q    <= (bit_cnt_q == 4'hF);
                        state_q   <= LOW;
                    end
                end
                LOW: begin
                    if (tick) begin
                        if (last_q) begin
                            ncs     <= 1'b1;
                            copi    <= 1'b0;
                            state_q <= GAP;
                        end else begin
                            sclk    <= 1'b1;
                            state_q <= HIGH;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        ready   <= 1'b1;
                        done    <= 1'b1;
                        rdata   <= rx_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: scoreboarded frames on a CLK_DIV=2 instance, plus directed
// reset-abort (CLK_DIV=3) and timing (CLK_DIV=5) checks on two further instances.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst, rst3, rst5;
    logic       start, start3, start5;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       lb;

    logic       ready, done, sclk, copi, ncs, cipo;
    logic [7:0] rdata;
    logic       ready3, done3, sclk3, copi3, ncs3;
    logic [7:0] rdata3;
    logic       ready5, done5, sclk5, copi5, ncs5;
    logic [7:0] rdata5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign cipo = lb ? copi : 1'b0;

    spi_controller #(.CLK_DIV(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .cipo(cipo), .sclk(sclk), .copi(copi),
        .ncs(ncs)
    );

    spi_controller #(.CLK_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .rw(rw), .addr(addr), .wdata(wdata),
        .ready(ready3), .done(done3), .rdata(rdata3), .cipo(copi3), .sclk(sclk3), .copi(copi3),
        .ncs(ncs3)
    );

    spi_controller #(.CLK_DIV(5)) u_dut5 (
        .clk(clk), .rst(rst5), .start(start5), .rw(rw), .addr(addr), .wdata(wdata),
        .ready(ready5), .done(done5), .rdata(rdata5), .cipo(copi5), .sclk(sclk5), .copi(copi5),
        .ncs(ncs5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] frame;
        logic [7:0]  rdata;
        int unsigned done_at;
        int unsigned ncs_low;
    } exp_t;

    exp_t exp_q[$];

    // Expected timing for CLK_DIV=2: ncs low 33H = 66, done at 34H = 68.
    task automatic push_exp(input logic [15:0] f, input logic [7:0] rd);
        exp_q.push_back('{frame: f, rdata: rd, done_at: 68, ncs_low: 66});
    endtask

    // Main-instance monitor: peripheral-side capture, register model and scoreboard.
    logic [15:0] cap       = '0;
    int          rises     = 0;
    int          since     = 0;
    int          nlow      = 0;
    int          done_cnt  = 0;
    logic        ncs_prev  = 1'b1;
    logic        sclk_prev = 1'b0;
    logic [7:0]  regs [5]  = '{default: 8'h00};
    exp_t        e;

    always @(negedge clk) begin
        if (ncs_prev && !ncs) begin
            since = 0;
            cap   = '0;
            rises = 0;
            nlow  = 1;
        end else begin
            since++;
            if (!ncs) nlow++;
        end
        if (sclk && !sclk_prev) begin
            cap = {cap[14:0], copi};
            rises++;
        end
        if (ncs && !ncs_prev && rises == 16 && cap[15] && cap[14:8] < 7'd5) begin
            regs[cap[10:8]] = cap[7:0];
        end
        if (done) begin
            done_cnt++;
            check("done with pending frame", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("frame bits", 32'(cap), 32'(e.frame));
                check("sclk rises", rises, 16);
                check("ncs low cycles", nlow, e.ncs_low);
                check("done cycle", since, e.done_at);
                check("rdata", 32'(rdata), 32'(e.rdata));
            end
        end
        ncs_prev  = ncs;
        sclk_prev = sclk;
    end

    int done3_cnt = 0;
    always @(negedge clk) begin
        if (done3) done3_cnt++;
    end

    // CLK_DIV=5 monitor: width of every high phase and of low phases between two highs.
    int   run5 = 0;
    logic sclk5_prev = 1'b0;
    logic seen_fall5 = 1'b0;
    int   min_hi = 1000, max_hi = 0, min_lo = 1000, max_lo = 0;

    always @(negedge clk) begin
        if (sclk5 != sclk5_prev) begin
            if (sclk5_prev) begin
                if (run5 < min_hi) min_hi = run5;
                if (run5 > max_hi) max_hi = run5;
                seen_fall5 = 1'b1;
            end else if (seen_fall5) begin
                if (run5 < min_lo) min_lo = run5;
                if (run5 > max_lo) max_lo = run5;
            end
            run5 = 1;
        end else begin
            run5++;
        end
        if (ncs5) seen_fall5 = 1'b0;
        sclk5_prev = sclk5;
    end

    function automatic logic get_done(input int idx);
        case (idx)
            0:       return done;
            1:       return done3;
            default: return done5;
        endcase
    endfunction

    function automatic logic [7:0] get_rdata(input int idx);
        case (idx)
            0:       return rdata;
            1:       return rdata3;
            default: return rdata5;
        endcase
    endfunction

    task automatic set_start(input int idx, input logic v);
        case (idx)
            0:       start = v;
            1:       start3 = v;
            default: start5 = v;
        endcase
    endtask

    task automatic drive(input logic [15:0] f);
        rw    = f[15];
        addr  = f[14:8];
        wdata = f[7:0];
    endtask

    // Returns the number of clock edges from the accept edge to the done cycle.
    task automatic wait_done(input int idx, output int cyc);
        cyc = 0;
        while (!get_done(idx) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("done within budget", 32'(cyc < 400), 1);
    endtask

    task automatic run_frame(input int idx, input logic [15:0] f, output int cyc,
                             output logic [7:0] rd);
        drive(f);
        set_start(idx, 1'b1);
        @(negedge clk);
        set_start(idx, 1'b0);
        wait_done(idx, cyc);
        rd = get_rdata(idx);
    endtask

    int         cyc;
    int         d0;
    logic [7:0] rd;

    initial begin
        rst = 1'b0; rst3 = 1'b0; rst5 = 1'b0;
        start = 1'b0; start3 = 1'b0; start5 = 1'b0;
        lb = 1'b0;
        drive(16'h0000);
        #1;
        rst = 1'b1; rst3 = 1'b1; rst5 = 1'b1;
        #1;
        check("reset ready", ready, 1);
        check("reset done", done, 0);
        check("reset rdata", 32'(rdata), 0);
        check("reset sclk", sclk, 0);
        check("reset copi", copi, 0);
        check("reset ncs", ncs, 1);
        @(negedge clk);
        rst = 1'b0; rst3 = 1'b0; rst5 = 1'b0;
        repeat (2) @(negedge clk);

        // Write 0x80 to PWM duty (0x04).
        push_exp(16'h8480, 8'h00);
        run_frame(0, 16'h8480, cyc, rd);
        @(negedge clk);

        // Back-to-back with start held high.
        push_exp(16'h80FF, 8'h00);
        drive(16'h80FF);
        start = 1'b1;
        @(negedge clk);
        push_exp(16'h82A5, 8'h00);
        drive(16'h82A5);
        wait_done(0, cyc);
        @(negedge clk);
        check("b2b ncs fall after done", ncs, 0);
        start = 1'b0;
        wait_done(0, cyc);
        @(negedge clk);
        check("reg 0x00", 32'(regs[0]), 32'h0000_00FF);
        check("reg 0x02", 32'(regs[2]), 32'h0000_00A5);
        check("reg 0x04", 32'(regs[4]), 32'h0000_0080);

        // Stray start mid-frame with different inputs.
        d0 = done_cnt;
        push_exp(16'h0311, 8'h00);
        drive(16'h0311);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        drive(16'hFFEE);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, cyc);
        repeat (80) @(negedge clk);
        check("single done for stray start", done_cnt - d0, 1);

        // Loopback capture.
        lb = 1'b1;
        push_exp(16'h813C, 8'h3C);
        run_frame(0, 16'h813C, cyc, rd);
        @(negedge clk);
        lb = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);

        // CLK_DIV=3: full frame, then reset at cycle 20 of the next one.
        run_frame(1, 16'hF0A5, cyc, rd);
        check("div3 done cycle", cyc, 102);
        check("div3 rdata", 32'(rd), 32'h0000_00A5);
        @(negedge clk);
        drive(16'hFFFF);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (20) @(negedge clk);
        check("div3 pre-reset ncs", ncs3, 0);
        check("div3 pre-reset copi", copi3, 1);
        d0 = done3_cnt;
        rst3 = 1'b1;
        #1;
        check("abort ncs", ncs3, 1);
        check("abort sclk", sclk3, 0);
        check("abort copi", copi3, 0);
        check("abort rdata", 32'(rdata3), 0);
        check("abort ready", ready3, 1);
        repeat (3) @(negedge clk);
        rst3 = 1'b0;
        repeat (120) @(negedge clk);
        check("no done after abort", done3_cnt - d0, 0);
        check("ready after abort", ready3, 1);
        run_frame(1, 16'h055A, cyc, rd);
        check("div3 post-reset done cycle", cyc, 102);
        check("div3 post-reset rdata", 32'(rd), 32'h0000_005A);

        // CLK_DIV=5 timing.
        run_frame(2, 16'hC3A5, cyc, rd);
        check("div5 done cycle", cyc, 170);
        check("div5 rdata", 32'(rd), 32'h0000_00A5);
        check("div5 min high width", min_hi, 5);
        check("div5 max high width", max_hi, 5);
        check("div5 min low width", min_lo, 5);
        check("div5 max low width", max_lo, 5);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
